// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory stage: FSM encoding and MEM/WB register layout.
package mem_access_stage_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mvalid;
   } wb_ctrl_t;

   typedef struct packed {
      wb_ctrl_t    ctrl;
      logic [31:0] read_data;
      logic [31:0] alu_out;
      logic [3:0]  wa3;
      logic [3:0]  mwa3;
      logic [31:0] wresult;
   } mem_wb_t;

   // Control bits forced into the W stage while the M stage is stalled.
   localparam wb_ctrl_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_access_stage_mem_wb_register.sv
// MEM/WB pipeline register: bubble insertion on stall, data fields hold.
module mem_wb_register
   import mem_access_stage_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    stall,
   input  mem_wb_t d,
   output mem_wb_t q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (stall) begin
         q.ctrl <= MEM_WB_BUBBLE;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: data-memory handshake with timeout/alignment checks, pipeline
// stall generation and the MEM/WB register feeding writeback.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [3:0]  WA3M,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        MemtoRegM,
   input  logic        MvalidM,
   input  logic [3:0]  MWA3M,
   input  logic [31:0] WResultM,
   input  logic        Float_startM,
   input  logic [31:0] FloatoutM,
   output logic        DReq,
   output logic        DWe,
   output logic [31:0] DAddr,
   output logic [31:0] DWData,
   input  logic        DRdy,
   input  logic [31:0] DRData,
   output logic        StallM,
   output logic        MemErr,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic [3:0]  WA3W,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic        MvalidW,
   output logic [3:0]  MWA3W,
   output logic [31:0] WResultW
);

   mem_state_e       state;
   mem_state_e       state_nxt;
   logic [CNT_W-1:0] count;
   logic             memop;
   logic             misalign;
   logic             timeout;
   logic             complete;
   logic             op_fault;
   mem_wb_t          wb_d;
   mem_wb_t          wb_q;

   assign memop    = MemWriteM | MemtoRegM;
   assign misalign = memop & (ALUResultM[1:0] != 2'b00);
   assign complete = (state == ST_ACCESS) & DRdy;
   // DRdy in the last allowed cycle takes priority over the timeout.
   assign timeout  = (state == ST_ACCESS) & (count == CNT_W'(TIMEOUT - 1)) & ~DRdy;
   assign op_fault = misalign | timeout;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         count <= '0;
      end else if (state == ST_IDLE) begin
         count <= '0;
      end else if (!DRdy) begin
         count <= count + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      StallM    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (memop && !misalign) begin
               state_nxt = ST_ACCESS;
               StallM    = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (DRdy || timeout) begin
               state_nxt = ST_IDLE;
            end else begin
               StallM = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Bus is driven only while a request is outstanding; no path from DRdy.
   assign DReq   = (state == ST_ACCESS);
   assign DWe    = DReq & MemWriteM;
   assign DAddr  = DReq ? ALUResultM : 32'h0;
   assign DWData = DReq ? WriteDataM : 32'h0;
   assign MemErr = op_fault;

   always_comb begin
      wb_d                 = '0;
      wb_d.ctrl.reg_write  = RegWriteM & ~op_fault;
      wb_d.ctrl.mem_to_reg = MemtoRegM & ~op_fault;
      wb_d.ctrl.mvalid     = MvalidM;
      wb_d.read_data       = complete ? DRData : 32'h0;
      wb_d.alu_out         = Float_startM ? FloatoutM : ALUResultM;
      wb_d.wa3             = WA3M;
      wb_d.mwa3            = MWA3M;
      wb_d.wresult         = WResultM;
   end

   mem_wb_register u_mem_wb (
      .clk   (CLK),
      .rst_n (RESETn),
      .stall (StallM),
      .d     (wb_d),
      .q     (wb_q)
   );

   assign ReadDataW = wb_q.read_data;
   assign ALUOutW   = wb_q.alu_out;
   assign WA3W      = wb_q.wa3;
   assign RegWriteW = wb_q.ctrl.reg_write;
   assign MemtoRegW = wb_q.ctrl.mem_to_reg;
   assign MvalidW   = wb_q.ctrl.mvalid;
   assign MWA3W     = wb_q.mwa3;
   assign WResultW  = wb_q.wresult;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the pipelined core; sits directly downstream of the EX/MEM state register and consumes its M-stage outputs.
- Performs load/store through a request/ready data-memory handshake with timeout and alignment checking, stalling the pipeline while an access is outstanding.
- Selects the ALU or float result and holds the MEM/WB pipeline register, producing the W-stage signals for writeback.

Parameters:
- TIMEOUT, 16, max cycles in ACCESS waiting for DRdy before abort (>=2)
- CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
- CLK  in  1  clock, rising edge
- RESETn  in  1  asynchronous active-low reset
- ALUResultM  in  32  address for load/store, or ALU result
- WriteDataM  in  32  store data
- WA3M  in  4  destination register
- RegWriteM  in  1  register write enable
- MemWriteM  in  1  store request
- MemtoRegM  in  1  load request
- MvalidM  in  1  multiplier result valid
- MWA3M  in  4  multiplier destination register
- WResultM  in  32  multiplier result
- Float_startM  in  1  instruction is a float op
- FloatoutM  in  32  float unit result
- DReq  out  1  data-memory request
- DWe  out  1  1=write, 0=read
- DAddr  out  32  word-aligned byte address
- DWData  out  32  store data
- DRdy  in  1  memory completes the request this cycle
- DRData  in  32  load data, valid when DRdy=1
- StallM  out  1  hold F/D/E stages and the EX/MEM register enable
- MemErr  out  1  one-cycle pulse: misaligned access or timeout
- ReadDataW  out  32  registered load data
- ALUOutW  out  32  registered non-memory result
- WA3W  out  4  registered destination
- RegWriteW  out  1  registered write enable
- MemtoRegW  out  1  registered load select
- MvalidW  out  1  registered multiplier valid
- MWA3W  out  4  registered multiplier destination
- WResultW  out  32  registered multiplier result

Behaviour:
- memop = MemWriteM | MemtoRegM. misalign = memop & (ALUResultM[1:0] != 0).
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when memop & !misalign.
  - ACCESS -> IDLE on DRdy or on timeout.
- DReq = 1 only in ACCESS. While in ACCESS: DWe = MemWriteM, DAddr = ALUResultM, DWData = WriteDataM. DAddr, DWData and DWe are 0 whenever DReq = 0.
- M-stage inputs are stable throughout ACCESS because StallM holds the upstream register.
- StallM (combinational):
  - 1 in IDLE when memop & !misalign
  - 1 in ACCESS when !DRdy & !timeout
  - 0 otherwise
- Minimum memory op latency is 2 cycles: request issued the cycle after the op arrives.
- Timeout counter:
  - Cleared on entry to ACCESS; increments each ACCESS cycle without DRdy.
  - timeout = (count == TIMEOUT-1) & !DRdy.
  - On timeout: return to IDLE, MemErr=1 for one cycle, stall releases.
- Misaligned op:
  - No request issued, no stall.
  - MemErr=1 in that cycle.
  - The op retires with RegWriteW=0 and MemtoRegW=0, so a store is dropped and a load writes nothing.
- MEM/WB register update each clock:
  - If StallM=1: load a bubble (RegWriteW=0, MvalidW=0, MemtoRegW=0); other W fields hold their previous values.
  - Else: capture the M-stage fields.
    - ALUOutW = Float_startM ? FloatoutM : ALUResultM.
    - ReadDataW = DRData if completing via DRdy, else 0.
    - RegWriteW = RegWriteM & !(misalign | timeout).
- DRdy while in IDLE is ignored.
- DRdy and timeout in the same cycle: DRdy wins, the access completes normally, and MemErr stays 0.
- Back-to-back memory ops:
  - After completion the FSM is in IDLE and the next op starts the cycle after.
  - Minimum 2 cycles per op; no combinational path from DRdy to DReq.
- Reset (asynchronous, any time including mid-ACCESS):
  - FSM to IDLE, counter 0, DReq=0, MemErr=0.
  - All W outputs 0.
  - An in-flight memory response is discarded.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, ACCESS=1'b1) and a MEM_WB bubble constant; both are reused by the hazard unit.
- One natural sub-module, mem_wb_register: the W-stage flops with bubble-insert and async reset. The FSM, counter and muxing stay in mem_access_stage.

Test Plan:
- ALU op, RegWriteM=1, ALUResultM=0x0000_1234, no memop -> StallM=0, DReq never 1; next edge ALUOutW=0x1234, RegWriteW=1.
- Load to 0x100, DRdy asserted on the 3rd ACCESS cycle with DRData=0xDEADBEEF -> DReq=1, DWe=0, DAddr=0x100 for 3 cycles; StallM=1 for 3 cycles, 0 in the DRdy cycle; ReadDataW=0xDEADBEEF, MemtoRegW=1, RegWriteW=1; bubbles (RegWriteW=0) during the stall.
- Store to 0x204, WriteDataM=0xA5A5A5A5, DRdy in the first ACCESS cycle -> DWe=1, DWData=0xA5A5A5A5; total stall 1 cycle; RegWriteW follows RegWriteM.
- Load to 0x102 (misaligned) -> no DReq, StallM=0, MemErr pulses once, RegWriteW=0.
- Load with DRdy never asserted, TIMEOUT=4 -> DReq high 4 cycles, MemErr pulse in the 4th, then IDLE; ReadDataW=0, RegWriteW=0. Repeat with DRdy on the 4th cycle -> normal completion, MemErr=0.
- Float op, Float_startM=1, FloatoutM=0x3F800000 -> ALUOutW=0x3F800000. RESETn low mid-ACCESS -> DReq drops immediately and all W outputs are 0; after release, a new load completes normally.
